// File: rtl/shift_arbiter.sv
// Two-requester front end time-sharing one external combinational right shifter.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module shift_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_amt,
    input  logic        req0_arith,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_amt,
    input  logic        req1_arith,
    output logic        req1_ready,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] sh_a,
    output logic [31:0] sh_b,
    output logic        sh_s,
    input  logic [31:0] sh_r,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

    state_t      state;
    logic [31:0] lat_a;
    logic [4:0]  lat_amt;
    logic        lat_arith;
    logic        grant_id;
    logic        grant_valid;
    logic        grant_sel;
    logic        accept;
    logic        rsp_fire;

`ifdef SHIFT_ARB_RR_EN
    logic prio;

    // On a tie the pointer decides; a lone request always wins.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_sel = prio;
        end else begin
            grant_sel = req1_valid;
        end
    end
`else
    logic unused_rr_init;
    assign unused_rr_init = RR_INIT;

    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_sel   = ~req0_valid;
    end
`endif

    // Ready is masked during reset so nothing is accepted while the block is held.
    assign accept     = (state == IDLE) && !reset && grant_valid;
    assign req0_ready = accept && !grant_sel;
    assign req1_ready = accept && grant_sel;

    assign rsp0_valid = (state == RESP) && !grant_id;
    assign rsp1_valid = (state == RESP) && grant_id;
    assign rsp_fire   = grant_id ? rsp1_ready : rsp0_ready;
    assign busy       = (state != IDLE);

    assign sh_a = lat_a;
    assign sh_b = {27'b0, lat_amt};
    assign sh_s = lat_arith & lat_a[31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_a     <= '0;
            lat_amt   <= '0;
            lat_arith <= 1'b0;
            grant_id  <= 1'b0;
            rsp_data  <= '0;
`ifdef SHIFT_ARB_RR_EN
            prio      <= RR_INIT;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_a     <= grant_sel ? req1_a : req0_a;
                        lat_amt   <= grant_sel ? req1_amt : req0_amt;
                        lat_arith <= grant_sel ? req1_arith : req0_arith;
                        grant_id  <= grant_sel;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    rsp_data <= sh_r;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        state <= IDLE;
`ifdef SHIFT_ARB_RR_EN
                        prio  <= ~grant_id;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
